// File: rtl/dac_spi_pkg.sv
// Shared types and constants for the DAC SPI transmitter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package dac_spi_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    SHIFT = 3'd2,
    HOLD  = 3'd3,
    LDAC  = 3'd4
  } state_t;

  // Bit of the GPO word that requests an LDAC pulse after the frame.
  localparam int   LOAD_FLAG_BIT = 32;
  // Idle level of sclk (mode 1: idles low, DAC samples on falling edges).
  localparam logic SPI_CPOL      = 1'b0;

  // Width able to hold counts 0..max_count-1, never narrower than one bit.
  function automatic int cnt_width(input int max_count);
    return (max_count > 1) ? $clog2(max_count) : 1;
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/spi_tick_gen.sv
// Enable-gated clock divider: one-cycle tick every CLK_DIV enabled cycles, plus half-period phase.
// Latency: first tick CLK_DIV enabled cycles after clear; tick is combinational from the counter.
// Backpressure: none; counter freezes while en_i is low, clr_i restarts it at phase 0.
module spi_tick_gen
  import dac_spi_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  input  logic clr_i,
  output logic tick_o,
  output logic phase_o
);

  localparam int CW = cnt_width(CLK_DIV);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          phase_q, phase_d;

  // phase 0: the next tick ends the sclk-high half (fall); phase 1: the next tick is a rise point.
  assign tick_o  = en_i && (cnt_q == CW'(CLK_DIV - 1));
  assign phase_o = phase_q;

  // Next-state for the divider count and half-period phase.
  always_comb begin
    cnt_d   = cnt_q;
    phase_d = phase_q;
    if (clr_i) begin
      cnt_d   = '0;
      phase_d = 1'b0;
    end else if (en_i) begin
      if (tick_o) begin
        cnt_d   = '0;
        phase_d = ~phase_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Divider state registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q   <= '0;
      phase_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

endmodule

// File: rtl/dac_spi_tx.sv
// Serialises one DAC frame from the GPO word over SPI mode 1 with SYNC and optional LDAC pulse.
// Latency: sync_n falls 1 cycle after start; busy lasts CS_SETUP+2*CLK_DIV*FRAME_BITS+CS_HOLD (+LDAC_WIDTH).
// Backpressure: start while busy is dropped and flagged on start_ignored; start in the done cycle is taken.
module dac_spi_tx
  import dac_spi_pkg::*;
#(
  parameter int FRAME_BITS = 24,
  parameter int CLK_DIV    = 4,
  parameter int CS_SETUP   = 2,
  parameter int CS_HOLD    = 2,
  parameter int LDAC_WIDTH = 3
) (
  input  logic         CLK100MHZ,
  input  logic         reset,
  input  logic         start,
  input  logic [127:0] data_in,
  output logic         busy,
  output logic         done,
  output logic         start_ignored,
  output logic         sclk,
  output logic         sdo,
  output logic         sync_n,
  output logic         ldac_n
);

  localparam int BW = cnt_width(FRAME_BITS);
  localparam int PW = cnt_width(max3(CS_SETUP, CS_HOLD, LDAC_WIDTH));

  // Bits of data_in that matter: the frame and the load flag.
  localparam logic [127:0] USED_MASK = (128'(1) << LOAD_FLAG_BIT) | ((128'(1) << FRAME_BITS) - 128'(1));

  state_t                state_q, state_d;
  logic [FRAME_BITS-1:0] sreg_q, sreg_d;
  logic [FRAME_BITS-1:0] shifted;
  logic [BW-1:0]         bit_q, bit_d;
  logic [PW-1:0]         cnt_q, cnt_d;
  logic                  load_q, load_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  ign_q, ign_d;
  logic                  sclk_q, sclk_d;
  logic                  sdo_q, sdo_d;
  logic                  sync_n_q, sync_n_d;
  logic                  ldac_n_q, ldac_n_d;
  logic                  start_acc;
  logic                  tick, phase;
  logic                  unused_data;

  assign unused_data = ^(data_in & ~USED_MASK);

  assign start_acc = start && (state_q == IDLE);

  spi_tick_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_tick (
    .clk_i  (CLK100MHZ),
    .rst_i  (reset),
    .en_i   (state_q == SHIFT),
    .clr_i  (start_acc),
    .tick_o (tick),
    .phase_o(phase)
  );

  // Frame sequencing: setup, bit shifting on divider ticks, hold, optional LDAC pulse.
  always_comb begin
    state_d  = state_q;
    sreg_d   = sreg_q;
    bit_d    = bit_q;
    cnt_d    = cnt_q;
    load_d   = load_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    ign_d    = start && (state_q != IDLE);
    sclk_d   = sclk_q;
    sdo_d    = sdo_q;
    sync_n_d = sync_n_q;
    ldac_n_d = ldac_n_q;
    shifted  = sreg_q << 1;
    case (state_q)
      IDLE: begin
        if (start) begin
          sreg_d   = data_in[FRAME_BITS-1:0];
          load_d   = data_in[LOAD_FLAG_BIT];
          sdo_d    = data_in[FRAME_BITS-1];
          bit_d    = '0;
          cnt_d    = '0;
          busy_d   = 1'b1;
          sync_n_d = 1'b0;
          sclk_d   = SPI_CPOL;
          state_d  = SETUP;
        end
      end
      SETUP: begin
        if (cnt_q == PW'(CS_SETUP - 1)) begin
          cnt_d   = '0;
          sclk_d  = ~SPI_CPOL;
          state_d = SHIFT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      SHIFT: begin
        if (tick) begin
          if (!phase) begin
            sclk_d = SPI_CPOL;
          end else if (bit_q == BW'(FRAME_BITS - 1)) begin
            // Low half of the last bit is over: frame body complete.
            sdo_d   = 1'b0;
            cnt_d   = '0;
            state_d = HOLD;
          end else begin
            sclk_d = ~SPI_CPOL;
            sreg_d = shifted;
            sdo_d  = shifted[FRAME_BITS-1];
            bit_d  = bit_q + 1'b1;
          end
        end
      end
      HOLD: begin
        if (cnt_q == PW'(CS_HOLD - 1)) begin
          cnt_d    = '0;
          sync_n_d = 1'b1;
          if (load_q) begin
            ldac_n_d = 1'b0;
            state_d  = LDAC;
          end else begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      LDAC: begin
        if (cnt_q == PW'(LDAC_WIDTH - 1)) begin
          cnt_d    = '0;
          ldac_n_d = 1'b1;
          busy_d   = 1'b0;
          done_d   = 1'b1;
          state_d  = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset drives pins to idle levels immediately.
  always_ff @(posedge CLK100MHZ or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      sreg_q   <= '0;
      bit_q    <= '0;
      cnt_q    <= '0;
      load_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      ign_q    <= 1'b0;
      sclk_q   <= SPI_CPOL;
      sdo_q    <= 1'b0;
      sync_n_q <= 1'b1;
      ldac_n_q <= 1'b1;
    end else begin
      state_q  <= state_d;
      sreg_q   <= sreg_d;
      bit_q    <= bit_d;
      cnt_q    <= cnt_d;
      load_q   <= load_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      ign_q    <= ign_d;
      sclk_q   <= sclk_d;
      sdo_q    <= sdo_d;
      sync_n_q <= sync_n_d;
      ldac_n_q <= ldac_n_d;
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign start_ignored = ign_q;
  assign sclk          = sclk_q;
  assign sdo           = sdo_q;
  assign sync_n        = sync_n_q;
  assign ldac_n        = ldac_n_q;

endmodule

// File: tb/tb_dac_spi_tx.sv
// Directed bench for dac_spi_tx: default build plus a CLK_DIV=1, FRAME_BITS=16 build.
// Latency: n/a.
// Backpressure: n/a.
module tb_dac_spi_tx;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         start_a = 1'b0;
  logic [127:0] data_a = '0;
  logic         start_b = 1'b0;
  logic [127:0] data_b = '0;

  logic busy_a, done_a, ign_a, sclk_a, sdo_a, sync_a, ldac_a;
  logic busy_b, done_b, ign_b, sclk_b, sdo_b, sync_b, ldac_b;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  dac_spi_tx u_dut_a (
    .CLK100MHZ    (clk),
    .reset        (reset),
    .start        (start_a),
    .data_in      (data_a),
    .busy         (busy_a),
    .done         (done_a),
    .start_ignored(ign_a),
    .sclk         (sclk_a),
    .sdo          (sdo_a),
    .sync_n       (sync_a),
    .ldac_n       (ldac_a)
  );

  dac_spi_tx #(
    .FRAME_BITS(16),
    .CLK_DIV   (1)
  ) u_dut_b (
    .CLK100MHZ    (clk),
    .reset        (reset),
    .start        (start_b),
    .data_in      (data_b),
    .busy         (busy_b),
    .done         (done_b),
    .start_ignored(ign_b),
    .sclk         (sclk_b),
    .sdo          (sdo_b),
    .sync_n       (sync_b),
    .ldac_n       (ldac_b)
  );

  // Pin monitors, sampled on the falling clock edge (outputs settle after rising edges).
  int          a_busy = 0, a_ldac = 0, a_done = 0, a_ign = 0, a_bits = 0, a_hi = 0, a_ovl = 0;
  int          a_run = 0, a_gap = 0;
  logic [31:0] a_word = '0;
  logic        a_prev = 1'b0;
  int          b_busy = 0, b_ldac = 0, b_done = 0, b_bits = 0, b_hi = 0;
  logic [31:0] b_word = '0;
  logic        b_prev = 1'b0;

  always @(negedge clk) begin
    if (busy_a) a_busy = a_busy + 1;
    if (!ldac_a) a_ldac = a_ldac + 1;
    if (done_a) a_done = a_done + 1;
    if (ign_a) a_ign = a_ign + 1;
    if (sclk_a) a_hi = a_hi + 1;
    if (!ldac_a && !sync_a) a_ovl = a_ovl + 1;
    if (a_prev && !sclk_a) begin
      a_word = {a_word[30:0], sdo_a};
      a_bits = a_bits + 1;
    end
    a_prev = sclk_a;
    if (sync_a) a_run = a_run + 1;
    else begin
      if (a_run > 0) a_gap = a_run;
      a_run = 0;
    end
  end

  always @(negedge clk) begin
    if (busy_b) b_busy = b_busy + 1;
    if (!ldac_b) b_ldac = b_ldac + 1;
    if (done_b) b_done = b_done + 1;
    if (sclk_b) b_hi = b_hi + 1;
    if (b_prev && !sclk_b) begin
      b_word = {b_word[30:0], sdo_b};
      b_bits = b_bits + 1;
    end
    b_prev = sclk_b;
  end

  int s_busy, s_ldac, s_done, s_ign, s_bits, s_hi, s_ovl;
  int cyc;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic snap_a();
    s_busy = a_busy; s_ldac = a_ldac; s_done = a_done; s_ign = a_ign;
    s_bits = a_bits; s_hi = a_hi; s_ovl = a_ovl;
  endtask

  task automatic snap_b();
    s_busy = b_busy; s_ldac = b_ldac; s_done = b_done; s_bits = b_bits; s_hi = b_hi;
  endtask

  task automatic send_a(input logic [127:0] d);
    start_a = 1'b1;
    data_a  = d;
    tick(1);
    start_a = 1'b0;
  endtask

  task automatic wait_done_a(input string tag, output int n);
    n = 0;
    do begin
      tick(1);
      n++;
    end while (!done_a && n < 1000);
    chk({tag, "_done_seen"}, {31'b0, done_a}, 32'd1);
  endtask

  task automatic wait_done_b(input string tag, output int n);
    n = 0;
    do begin
      tick(1);
      n++;
    end while (!done_b && n < 1000);
    chk({tag, "_done_seen"}, {31'b0, done_b}, 32'd1);
  endtask

  task automatic check_idle_a(input string tag);
    chk({tag, "_busy"},   {31'b0, busy_a}, 32'd0);
    chk({tag, "_sclk"},   {31'b0, sclk_a}, 32'd0);
    chk({tag, "_sdo"},    {31'b0, sdo_a},  32'd0);
    chk({tag, "_sync_n"}, {31'b0, sync_a}, 32'd1);
    chk({tag, "_ldac_n"}, {31'b0, ldac_a}, 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    // Reset values, checked before any clock edge.
    #2 reset = 1'b1;
    #1;
    check_idle_a("rst");
    chk("rst_done", {31'b0, done_a}, 32'd0);
    chk("rst_ign",  {31'b0, ign_a},  32'd0);
    tick(3);
    reset = 1'b0;
    tick(2);

    // 1: 0xABCDEF with load flag.
    snap_a();
    send_a(128'h1_00ABCDEF);
    chk("t1_sync_n_p1", {31'b0, sync_a}, 32'd0);
    chk("t1_busy_p1",   {31'b0, busy_a}, 32'd1);
    chk("t1_sdo_p1",    {31'b0, sdo_a},  32'd1);
    wait_done_a("t1", cyc);
    chk("t1_cycles", cyc, 32'd199);
    tick(3);
    chk("t1_busy_len", a_busy - s_busy, 32'd199);
    chk("t1_bits",     a_bits - s_bits, 32'd24);
    chk("t1_word",     {8'h0, a_word[23:0]}, 32'h00ABCDEF);
    chk("t1_sclk_hi",  a_hi - s_hi, 32'd96);
    chk("t1_ldac_len", a_ldac - s_ldac, 32'd3);
    chk("t1_ldac_ovl", a_ovl - s_ovl, 32'd0);
    chk("t1_done_cnt", a_done - s_done, 32'd1);

    // 2: 0x800001, no load; upper garbage except bit 32 must be ignored.
    snap_a();
    send_a({64'hDEAD_BEEF_CAFE_F00D, 31'h5555_1234, 1'b0, 8'hC3, 24'h800001});
    chk("t2_sdo_p1", {31'b0, sdo_a}, 32'd1);
    wait_done_a("t2", cyc);
    chk("t2_cycles", cyc, 32'd196);
    tick(3);
    chk("t2_busy_len", a_busy - s_busy, 32'd196);
    chk("t2_word",     {8'h0, a_word[23:0]}, 32'h00800001);
    chk("t2_ldac_len", a_ldac - s_ldac, 32'd0);
    chk("t2_done_cnt", a_done - s_done, 32'd1);

    // 3: second start at +50 is ignored.
    snap_a();
    send_a(128'h0_005A5A5A);
    tick(49);
    start_a = 1'b1;
    data_a  = 128'h1_00FFFFFF;
    tick(1);
    start_a = 1'b0;
    chk("t3_ign_pulse", {31'b0, ign_a}, 32'd1);
    tick(1);
    chk("t3_ign_clear", {31'b0, ign_a}, 32'd0);
    wait_done_a("t3", cyc);
    tick(250);
    chk("t3_word",     {8'h0, a_word[23:0]}, 32'h005A5A5A);
    chk("t3_busy_len", a_busy - s_busy, 32'd196);
    chk("t3_ldac_len", a_ldac - s_ldac, 32'd0);
    chk("t3_ign_cnt",  a_ign - s_ign, 32'd1);
    chk("t3_bits",     a_bits - s_bits, 32'd24);

    // 4: back-to-back frames, start in the done cycle.
    snap_a();
    send_a(128'h0_00123456);
    wait_done_a("t4a", cyc);
    start_a = 1'b1;
    data_a  = 128'h0_00654321;
    tick(1);
    start_a = 1'b0;
    chk("t4_busy_b2b", {31'b0, busy_a}, 32'd1);
    chk("t4_ign_b2b",  {31'b0, ign_a},  32'd0);
    wait_done_a("t4b", cyc);
    tick(3);
    chk("t4_gap",      a_gap, 32'd1);
    chk("t4_word",     a_word, 32'h56654321);
    chk("t4_bits",     a_bits - s_bits, 32'd48);
    chk("t4_done_cnt", a_done - s_done, 32'd2);
    chk("t4_busy_len", a_busy - s_busy, 32'd392);

    // 5: asynchronous reset mid-SHIFT, then a clean frame.
    snap_a();
    send_a(128'h1_00FFFFFF);
    tick(99);
    chk("t5_pre_sclk", {31'b0, sclk_a}, 32'd1);
    chk("t5_pre_sync", {31'b0, sync_a}, 32'd0);
    reset = 1'b1;
    #1;
    check_idle_a("t5_rst");
    tick(2);
    reset = 1'b0;
    tick(2);
    chk("t5_no_done", a_done - s_done, 32'd0);
    snap_a();
    send_a(128'h1_000F0F0F);
    chk("t5_sdo_p1", {31'b0, sdo_a}, 32'd0);
    wait_done_a("t5", cyc);
    chk("t5_cycles", cyc, 32'd199);
    tick(3);
    chk("t5_word",     {8'h0, a_word[23:0]}, 32'h000F0F0F);
    chk("t5_bits",     a_bits - s_bits, 32'd24);
    chk("t5_ldac_len", a_ldac - s_ldac, 32'd3);

    // 6: CLK_DIV=1, FRAME_BITS=16 build.
    snap_b();
    start_b = 1'b1;
    data_b  = 128'h0_0000A5A5;
    tick(1);
    start_b = 1'b0;
    chk("t6_sync_n_p1", {31'b0, sync_b}, 32'd0);
    chk("t6_sdo_p1",    {31'b0, sdo_b},  32'd1);
    wait_done_b("t6", cyc);
    chk("t6_cycles", cyc, 32'd36);
    tick(3);
    chk("t6_busy_len", b_busy - s_busy, 32'd36);
    chk("t6_word",     {16'h0, b_word[15:0]}, 32'h0000A5A5);
    chk("t6_bits",     b_bits - s_bits, 32'd16);
    chk("t6_sclk_hi",  b_hi - s_hi, 32'd16);
    chk("t6_ldac_len", b_ldac - s_ldac, 32'd0);
    chk("t6_done_cnt", b_done - s_done, 32'd1);
    chk("t6_ign",      {31'b0, ign_b}, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
